// File: rtl/bram_mem_if.sv
// Memory bus between the processor and bram_mem: byte address, read strobe,
// lane-replicated write data with byte mask, and read-side handshake back.
interface bram_mem_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        mem_rbusy;
    logic        mem_err;

    modport master (
        output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        input  mem_rdata, mem_rdata_valid, mem_rbusy, mem_err
    );

    modport slave (
        input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
        output mem_rdata, mem_rdata_valid, mem_rbusy, mem_err
    );
endinterface

// File: rtl/bram_mem.sv
// bram_mem: single-port 32-bit word RAM with byte-lane writes, configurable
// read latency (1..4) and a valid/busy read handshake.
// Optional feature macro BRAM_MEM_ERR_EN: when defined, word indices >= WORDS
// are flagged on mem_err, writes to them are dropped and reads return zero.
// When undefined, the index wraps modulo WORDS, which must be a power of two.
module bram_mem #(
    parameter int unsigned WORDS        = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic       clk,
    input logic       reset_n,
    bram_mem_if.slave bus
);

    localparam int unsigned AW = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam int          RL = int'(READ_LATENCY);

    logic [31:0]             mem_q [WORDS];
    logic [AW-1:0]           idx;
    logic                    oor;
    logic                    busy;
    logic                    accept;
    logic [31:0]             rd_word;
    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] valid_d;
    logic [31:0]             data_q [READ_LATENCY];
    logic                    err_q;
    logic                    err_d;

    assign idx = bus.mem_addr[AW+1:2];

`ifdef BRAM_MEM_ERR_EN
    logic unused_addr;
    assign oor         = {2'b00, bus.mem_addr[31:2]} >= WORDS;
    assign unused_addr = ^bus.mem_addr[1:0];
`else
    logic unused_addr;
    assign oor         = 1'b0;
    assign unused_addr = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};
`endif

    // Busy while a read sits in any stage except the final (output) one.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RL - 1; i++) begin
            busy = busy | valid_q[i];
        end
    end

    // Accept decision, array read data and the valid-bit shift.
    always_comb begin
        accept     = bus.mem_rstrb && !busy;
        rd_word    = oor ? 32'h0 : mem_q[idx];
        err_d      = oor && (accept || (bus.mem_wmask != 4'h0));
        valid_d    = '0;
        valid_d[0] = accept;
        for (int i = 1; i < RL; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    // Array write port; non-blocking update gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (!oor) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) begin
                    mem_q[idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Latency pipeline; each data stage loads only when a read enters it, so
    // the last stage holds the most recently completed read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < RL; i++) begin
                data_q[i] <= 32'h0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            if (accept) begin
                data_q[0] <= rd_word;
            end
            for (int i = 1; i < RL; i++) begin
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign bus.mem_rdata       = data_q[RL-1];
    assign bus.mem_rdata_valid = valid_q[RL-1];
    assign bus.mem_rbusy       = busy;
    assign bus.mem_err         = err_q;

endmodule

// File: tb/tb_bram_mem.sv
// Directed bench for bram_mem: four instances (READ_LATENCY 1..4, WORDS 256)
// share clock and reset; expected values are hand-computed constants.
module tb_bram_mem;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    bram_mem_if b1 ();
    bram_mem_if b2 ();
    bram_mem_if b3 ();
    bram_mem_if b4 ();

    bram_mem #(.WORDS(256), .READ_LATENCY(1)) u_l1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    bram_mem #(.WORDS(256), .READ_LATENCY(2)) u_l2 (.clk(clk), .reset_n(reset_n), .bus(b2));
    bram_mem #(.WORDS(256), .READ_LATENCY(3)) u_l3 (.clk(clk), .reset_n(reset_n), .bus(b3));
    bram_mem #(.WORDS(256), .READ_LATENCY(4)) u_l4 (.clk(clk), .reset_n(reset_n), .bus(b4));

`ifdef BRAM_MEM_ERR_EN
    localparam logic        ExpErr     = 1'b1;
    localparam logic [31:0] ExpOorRd   = 32'h0000_0000;
    localparam logic [31:0] ExpWord0   = 32'h1234_5678;
`else
    localparam logic        ExpErr     = 1'b0;
    localparam logic [31:0] ExpOorRd   = 32'hFFFF_FFFF;
    localparam logic [31:0] ExpWord0   = 32'hFFFF_FFFF;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        b1.mem_addr = a; b1.mem_wdata = d; b1.mem_wmask = m;
        tick();
        b1.mem_wmask = 4'h0;
    endtask

    task automatic rd1(input logic [31:0] a);
        b1.mem_addr = a; b1.mem_rstrb = 1'b1;
        tick();
        b1.mem_rstrb = 1'b0;
    endtask

    task automatic idle_bus();
        b1.mem_addr = '0; b1.mem_rstrb = 1'b0; b1.mem_wdata = '0; b1.mem_wmask = '0;
        b2.mem_addr = '0; b2.mem_rstrb = 1'b0; b2.mem_wdata = '0; b2.mem_wmask = '0;
        b3.mem_addr = '0; b3.mem_rstrb = 1'b0; b3.mem_wdata = '0; b3.mem_wmask = '0;
        b4.mem_addr = '0; b4.mem_rstrb = 1'b0; b4.mem_wdata = '0; b4.mem_wmask = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        idle_bus();
        @(negedge clk);
        tick();

        // Outputs while in reset
        check("rst_rdata", b1.mem_rdata, 32'h0);
        check("rst_valid", {31'h0, b1.mem_rdata_valid}, 32'h0);
        check("rst_busy", {31'h0, b1.mem_rbusy}, 32'h0);
        check("rst_err", {31'h0, b1.mem_err}, 32'h0);
        check("rst_busy_l3", {31'h0, b3.mem_rbusy}, 32'h0);
        reset_n = 1'b1;
        tick();

        // L1: write then read word 0
        wr1(32'h0, 32'h1234_5678, 4'hF);
        rd1(32'h0);
        check("l1_valid", {31'h0, b1.mem_rdata_valid}, 32'h1);
        check("l1_rdata", b1.mem_rdata, 32'h1234_5678);
        check("l1_busy", {31'h0, b1.mem_rbusy}, 32'h0);
        tick();
        check("l1_valid_drop", {31'h0, b1.mem_rdata_valid}, 32'h0);
        check("l1_rdata_hold", b1.mem_rdata, 32'h1234_5678);

        // L1: byte-lane write, then back-to-back reads
        wr1(32'h10, 32'hDEAD_BEEF, 4'hF);
        wr1(32'h12, 32'h1155_2233, 4'b0100);
        b1.mem_addr = 32'h10; b1.mem_rstrb = 1'b1;
        tick();
        check("lane_rdata", b1.mem_rdata, 32'hDE55_BEEF);
        b1.mem_addr = 32'h0;
        tick();
        b1.mem_rstrb = 1'b0;
        check("b2b_valid", {31'h0, b1.mem_rdata_valid}, 32'h1);
        check("b2b_rdata", b1.mem_rdata, 32'h1234_5678);

        // L3: busy window, dropped strobes, next accept at edge 3
        b3.mem_addr = 32'h8; b3.mem_wdata = 32'hAAAA_0001; b3.mem_wmask = 4'hF;
        tick();
        b3.mem_addr = 32'hC; b3.mem_wdata = 32'hBBBB_0002;
        tick();
        b3.mem_wmask = 4'h0;
        b3.mem_addr = 32'h8; b3.mem_rstrb = 1'b1;
        tick();                                   // edge 0: accept word 2
        check("l3_e0_busy", {31'h0, b3.mem_rbusy}, 32'h1);
        check("l3_e0_valid", {31'h0, b3.mem_rdata_valid}, 32'h0);
        b3.mem_addr = 32'hC;                      // strobe held from here on
        tick();                                   // edge 1: dropped
        check("l3_e1_busy", {31'h0, b3.mem_rbusy}, 32'h1);
        check("l3_e1_valid", {31'h0, b3.mem_rdata_valid}, 32'h0);
        tick();                                   // edge 2: completes, strobe dropped
        check("l3_e2_valid", {31'h0, b3.mem_rdata_valid}, 32'h1);
        check("l3_e2_rdata", b3.mem_rdata, 32'hAAAA_0001);
        check("l3_e2_busy", {31'h0, b3.mem_rbusy}, 32'h0);
        tick();                                   // edge 3: accept word 3
        b3.mem_rstrb = 1'b0;
        check("l3_e3_busy", {31'h0, b3.mem_rbusy}, 32'h1);
        check("l3_e3_valid", {31'h0, b3.mem_rdata_valid}, 32'h0);
        check("l3_e3_rdata_hold", b3.mem_rdata, 32'hAAAA_0001);
        tick();
        tick();
        check("l3_e5_valid", {31'h0, b3.mem_rdata_valid}, 32'h1);
        check("l3_e5_rdata", b3.mem_rdata, 32'hBBBB_0002);
        tick();
        check("l3_e6_valid", {31'h0, b3.mem_rdata_valid}, 32'h0);

        // L2: read/write collision returns the old word
        b2.mem_addr = 32'h20; b2.mem_wdata = 32'h1; b2.mem_wmask = 4'hF;
        tick();
        b2.mem_wdata = 32'h2; b2.mem_rstrb = 1'b1;
        tick();
        b2.mem_wmask = 4'h0; b2.mem_rstrb = 1'b0;
        check("l2_busy", {31'h0, b2.mem_rbusy}, 32'h1);
        tick();
        check("l2_coll_valid", {31'h0, b2.mem_rdata_valid}, 32'h1);
        check("l2_coll_rdata", b2.mem_rdata, 32'h1);
        b2.mem_rstrb = 1'b1;
        tick();
        b2.mem_rstrb = 1'b0;
        b2.mem_wdata = 32'h3; b2.mem_wmask = 4'hF;   // write while read in flight
        tick();
        b2.mem_wmask = 4'h0;
        check("l2_next_rdata", b2.mem_rdata, 32'h2);
        b2.mem_rstrb = 1'b1;
        tick();
        b2.mem_rstrb = 1'b0;
        tick();
        check("l2_late_wr_rdata", b2.mem_rdata, 32'h3);

        // L1: out-of-range write and read (word 256)
        wr1(32'h400, 32'hFFFF_FFFF, 4'hF);
        check("oor_wr_err", {31'h0, b1.mem_err}, {31'h0, ExpErr});
        tick();
        check("oor_idle_err", {31'h0, b1.mem_err}, 32'h0);
        rd1(32'h400);
        check("oor_rd_err", {31'h0, b1.mem_err}, {31'h0, ExpErr});
        check("oor_rd_valid", {31'h0, b1.mem_rdata_valid}, 32'h1);
        check("oor_rd_rdata", b1.mem_rdata, ExpOorRd);
        rd1(32'h0);
        check("oor_word0", b1.mem_rdata, ExpWord0);
        check("oor_err_clear", {31'h0, b1.mem_err}, 32'h0);

        // L4: reset two cycles after accept discards the read
        b4.mem_addr = 32'h30; b4.mem_wdata = 32'hCAFE_F00D; b4.mem_wmask = 4'hF;
        tick();
        b4.mem_wmask = 4'h0; b4.mem_rstrb = 1'b1;
        tick();                                   // accept
        b4.mem_rstrb = 1'b0;
        check("l4_busy", {31'h0, b4.mem_rbusy}, 32'h1);
        tick();
        tick();
        check("l4_pre_rst_valid", {31'h0, b4.mem_rdata_valid}, 32'h0);
        reset_n = 1'b0;
        #1;
        check("l4_rst_busy", {31'h0, b4.mem_rbusy}, 32'h0);
        check("l4_rst_rdata", b4.mem_rdata, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("l4_post_valid", {31'h0, b4.mem_rdata_valid}, 32'h0);
            check("l4_post_rdata", b4.mem_rdata, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
